// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, status flags and accumulator.
// Define ALU_PIPE_MUL_EN to enable the iterative shift-add multiply on opcode 12.
module alu_pipe #(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [3:0]       operator,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);

    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_AND     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_XOR     = 4'd4;
    localparam logic [3:0] OP_SHL     = 4'd5;
    localparam logic [3:0] OP_SHR     = 4'd6;
    localparam logic [3:0] OP_SRA     = 4'd7;
    localparam logic [3:0] OP_SLT     = 4'd8;
    localparam logic [3:0] OP_SLTU    = 4'd9;
    localparam logic [3:0] OP_ACC_LD  = 4'd10;
    localparam logic [3:0] OP_ACC_ADD = 4'd11;
    localparam logic [3:0] OP_MUL     = 4'd12;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] acc;

    logic busy, s2_load, take;

    assign s2_load  = s1_valid && !busy && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign take     = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t            mstate, mstate_nxt;
    logic [SHW-1:0]     mul_cnt;
    logic [2*WIDTH-1:0] mul_prod;

    assign busy = (mstate == M_RUN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mstate   <= M_IDLE;
            mul_cnt  <= '0;
            mul_prod <= '0;
        end else begin
            mstate <= mstate_nxt;
            if (take && operator == OP_MUL) begin
                mul_cnt  <= '0;
                mul_prod <= '0;
            end else if (mstate == M_RUN) begin
                if (s1_b[mul_cnt])
                    mul_prod <= mul_prod + ({{WIDTH{1'b0}}, s1_a} << mul_cnt);
                mul_cnt <= mul_cnt + 1'b1;
            end
        end
    end

    // DONE can hand off and accept a fresh multiply in the same cycle.
    always_comb begin
        mstate_nxt = mstate;
        case (mstate)
            M_RUN: if (mul_cnt == SHW'(WIDTH-1)) mstate_nxt = M_DONE;
            default: begin
                if (take && operator == OP_MUL)
                    mstate_nxt = M_RUN;
                else if (mstate == M_DONE && s2_load)
                    mstate_nxt = M_IDLE;
            end
        endcase
    end
`else
    assign busy = 1'b0;
`endif

    logic [WIDTH:0]   add_sum, sub_dif, acc_sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] nxt_res, nxt_acc;
    logic             nxt_carry, nxt_ovf, nxt_ill, nxt_zero;

    assign add_sum = {1'b0, s1_a} + {1'b0, s1_b};
    assign sub_dif = {1'b0, s1_a} - {1'b0, s1_b};
    assign acc_sum = {1'b0, acc} + {1'b0, s1_a};
    assign shamt   = s1_b[SHW-1:0];

    always_comb begin
        nxt_res   = '0;
        nxt_acc   = acc;
        nxt_carry = 1'b0;
        nxt_ovf   = 1'b0;
        nxt_ill   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                nxt_res   = add_sum[WIDTH-1:0];
                nxt_carry = add_sum[WIDTH];
                nxt_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                nxt_res   = sub_dif[WIDTH-1:0];
                nxt_carry = sub_dif[WIDTH];
                nxt_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_dif[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:  nxt_res = s1_a & s1_b;
            OP_OR:   nxt_res = s1_a | s1_b;
            OP_XOR:  nxt_res = s1_a ^ s1_b;
            OP_SHL:  nxt_res = s1_a << shamt;
            OP_SHR:  nxt_res = s1_a >> shamt;
            OP_SRA:  nxt_res = WIDTH'($signed(s1_a) >>> shamt);
            OP_SLT:  nxt_res = {{(WIDTH-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
            OP_SLTU: nxt_res = {{(WIDTH-1){1'b0}}, s1_a < s1_b};
            OP_ACC_LD: begin
                nxt_res = s1_a;
                nxt_acc = s1_a;
            end
            OP_ACC_ADD: begin
                nxt_res   = acc_sum[WIDTH-1:0];
                nxt_acc   = acc_sum[WIDTH-1:0];
                nxt_carry = acc_sum[WIDTH];
                nxt_ovf   = (acc[WIDTH-1] == s1_a[WIDTH-1]) && (acc_sum[WIDTH-1] != acc[WIDTH-1]);
            end
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: begin
                nxt_res   = mul_prod[WIDTH-1:0];
                nxt_carry = |mul_prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: nxt_ill = 1'b1;
        endcase
        nxt_zero = !nxt_ill && (nxt_res == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (take) begin
            s1_valid <= 1'b1;
            s1_a     <= input_a;
            s1_b     <= input_b;
            s1_op    <= operator;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Accumulator moves only with the S1->S2 transfer, so a stalled beat updates it once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            illegal   <= 1'b0;
            acc       <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            result    <= nxt_res;
            flags     <= {nxt_zero, nxt_res[WIDTH-1], nxt_carry, nxt_ovf};
            illegal   <= nxt_ill;
            acc       <= nxt_acc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8).
module tb_alu_pipe;

    logic       clock, reset;
    logic       in_valid, in_ready, out_valid, out_ready, illegal;
    logic [7:0] input_a, input_b, result;
    logic [3:0] operator, flags;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .input_a(input_a), .input_b(input_b), .operator(operator),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one beat, waits for its result; lat = clocks from drive to out_valid, -1 on timeout.
    task automatic run_beat(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] r, output logic [3:0] f, output logic il,
                            output int lat);
        int n;
        @(negedge clock);
        in_valid = 1'b1; operator = op; input_a = a; input_b = b; out_ready = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clock); #1; n++;
        end
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clock); lat++; @(negedge clock);
        end
        r = result; f = flags; il = illegal;
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operator = '0; input_a = '0; input_b = '0;
        repeat (2) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b r=%h f=%b il=%b, want 0 00 0000 0",
                     out_valid, result, flags, illegal);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_sub;
        logic [7:0] r; logic [3:0] f; logic il; int lat;
        run_beat(4'd0, 8'h7F, 8'h01, r, f, il, lat);
        checks++;
        if (lat !== 2 || r !== 8'h80 || f !== 4'b0101 || il !== 1'b0) begin
            errors++; $display("FAIL add_7f_01: lat=%0d r=%h f=%b il=%b want 2 80 0101 0", lat, r, f, il);
        end
        run_beat(4'd1, 8'h00, 8'h01, r, f, il, lat);
        checks++;
        if (lat !== 2 || r !== 8'hFF || f !== 4'b0110 || il !== 1'b0) begin
            errors++; $display("FAIL sub_00_01: lat=%0d r=%h f=%b want 2 ff 0110", lat, r, f);
        end
        run_beat(4'd1, 8'h05, 8'h05, r, f, il, lat);
        checks++;
        if (r !== 8'h00 || f !== 4'b1000) begin
            errors++; $display("FAIL sub_05_05: r=%h f=%b want 00 1000", r, f);
        end
        run_beat(4'd8, 8'hFE, 8'h01, r, f, il, lat);
        checks++;
        if (r !== 8'h01 || f !== 4'b0000) begin
            errors++; $display("FAIL slt_signed: r=%h f=%b want 01 0000", r, f);
        end
        run_beat(4'd9, 8'hFE, 8'h01, r, f, il, lat);
        checks++;
        if (r !== 8'h00 || f !== 4'b1000) begin
            errors++; $display("FAIL sltu: r=%h f=%b want 00 1000", r, f);
        end
    endtask

    task automatic test_shift_illegal;
        logic [7:0] r; logic [3:0] f; logic il; int lat;
        run_beat(4'd7, 8'h90, 8'd3, r, f, il, lat);
        checks++;
        if (r !== 8'hF2 || f !== 4'b0100 || il !== 1'b0) begin
            errors++; $display("FAIL sra_90_3: r=%h f=%b want f2 0100", r, f);
        end
        run_beat(4'd5, 8'h81, 8'd9, r, f, il, lat);
        checks++;
        if (r !== 8'h02 || f !== 4'b0000) begin
            errors++; $display("FAIL shl_81_9: r=%h f=%b want 02 0000", r, f);
        end
        run_beat(4'd6, 8'h90, 8'd4, r, f, il, lat);
        checks++;
        if (r !== 8'h09 || f !== 4'b0000) begin
            errors++; $display("FAIL shr_90_4: r=%h f=%b want 09 0000", r, f);
        end
        run_beat(4'd14, 8'h12, 8'h34, r, f, il, lat);
        checks++;
        if (lat !== 2 || r !== 8'h00 || f !== 4'b0000 || il !== 1'b1) begin
            errors++; $display("FAIL op14_illegal: lat=%0d r=%h f=%b il=%b want 2 00 0000 1", lat, r, f, il);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_r [4];
        int sent, got;
        bit dropped;
        for (int i = 0; i < 4; i++) exp_r[i] = 8'(i * 16 + 8);
        sent = 0; got = 0; dropped = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clock);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            operator  = 4'd0;
            input_a   = 8'(sent * 16 + 3);
            input_b   = 8'h05;
            #1;
            if (out_valid) begin
                checks++;
                if (result !== exp_r[got]) begin
                    errors++; $display("FAIL b2b_result[%0d]: got %h want %h", got, result, exp_r[got]);
                end
                if (out_ready) got++;
            end
            if (in_valid && !in_ready) dropped = 1;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d beats want 4", got);
        end
        checks++;
        if (!dropped) begin
            errors++; $display("FAIL b2b_backpressure: in_ready never dropped, want drop");
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_no_dup: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_acc_stall;
        logic [7:0] r; logic [3:0] f; logic il; int lat;
        @(negedge clock);
        out_ready = 1'b0;
        in_valid = 1'b1; operator = 4'd10; input_a = 8'hF0; input_b = 8'h00;
        @(posedge clock);
        @(negedge clock);
        operator = 4'd11; input_a = 8'h20;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'hF0 || f !== f || flags !== 4'b0100) begin
            errors++; $display("FAIL acc_ld: v=%b r=%h f=%b want 1 f0 0100", out_valid, result, flags);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h10 || flags !== 4'b0010) begin
            errors++; $display("FAIL acc_add: v=%b r=%h f=%b want 1 10 0010", out_valid, result, flags);
        end
        run_beat(4'd11, 8'h00, 8'h00, r, f, il, lat);
        checks++;
        if (r !== 8'h10 || f !== 4'b0000) begin
            errors++; $display("FAIL acc_single_update: r=%h f=%b want 10 0000", r, f);
        end
    endtask

    task automatic test_mul;
`ifdef ALU_PIPE_MUL_EN
        int lat;
        bit ready_seen;
        @(negedge clock);
        in_valid = 1'b1; operator = 4'd12; input_a = 8'd20; input_b = 8'd13; out_ready = 1'b1;
        @(posedge clock);
        lat = 1; ready_seen = 0;
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) ready_seen = 1;
            @(posedge clock); lat++; @(negedge clock);
        end
        checks++;
        if (lat !== 10 || result !== 8'h04 || flags !== 4'b0010 || illegal !== 1'b0) begin
            errors++; $display("FAIL mul_20_13: lat=%0d r=%h f=%b want 10 04 0010", lat, result, flags);
        end
        checks++;
        if (ready_seen) begin
            errors++; $display("FAIL mul_busy: in_ready was 1 during multiply, want 0");
        end
        @(negedge clock);
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mul_reset_valid: got %b want 0", out_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mul_reset_ready: got %b want 1", in_ready);
        end
        repeat (12) @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mul_discarded: out_valid=%b want 0", out_valid);
        end
`else
        logic [7:0] r; logic [3:0] f; logic il; int lat;
        run_beat(4'd12, 8'd20, 8'd13, r, f, il, lat);
        checks++;
        if (lat !== 2 || r !== 8'h00 || f !== 4'b0000 || il !== 1'b1) begin
            errors++; $display("FAIL op12_illegal: lat=%0d r=%h f=%b il=%b want 2 00 0000 1", lat, r, f, il);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift_illegal();
        test_back_to_back();
        test_acc_stall();
        test_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
